// File: rtl/ysyx_040729_alu_mdu.sv
// ysyx_040729_alu_mdu -- iterative RV64M multiply/divide unit.
//
// Multiplies by shift-add and divides by restoring division, one bit per
// cycle. Divide-by-zero and signed overflow bypass the iteration and finish
// one cycle after acceptance. Word (OP-32) ops work on the low half of the
// operands and always return a result sign-extended from bit 31.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready only in IDLE, not during flush)
//   src1, src2            rs1 (multiplicand/dividend), rs2 (multiplier/divisor)
//   func3                 RV M func3 (mul, mulh, mulhsu, mulhu, div, divu, rem, remu)
//   is_word               OP-32 variant
//   flush                 abort any operation, return to IDLE
//   out_valid / out_ready result handshake; result is held under backpressure
//   result                final result
//   busy                  unit is not IDLE
module ysyx_040729_alu_mdu #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic [2:0]            func3,
  input  logic                  is_word,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy
);

  localparam int W = DATA_WIDTH;
  localparam int H = DATA_WIDTH / 2;
  localparam logic [H-1:0] MIN_H = {1'b1, {(H-1){1'b0}}};
  localparam logic [W-1:0] MIN_W = {1'b1, {(W-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] ITER_W = CNT_WIDTH'(W);
  localparam logic [CNT_WIDTH-1:0] ITER_H = CNT_WIDTH'(H);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_next;

  // Extend a half-width value to full width, signed or unsigned.
  function automatic logic [W-1:0] ext_half(input logic [H-1:0] v, input logic sgn);
    return {{H{sgn & v[H-1]}}, v};
  endfunction

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  logic [CNT_WIDTH-1:0] cnt;
  logic [2:0]           op_f3;
  logic                 op_word;
  logic                 neg_q;     // product / quotient sign
  logic                 neg_r;     // remainder sign (follows dividend)
  logic                 fast_q;
  logic [W-1:0]         fast_val;
  logic [2*W-1:0]       acc;
  logic [2*W-1:0]       mcand;
  logic [W-1:0]         mplier;
  logic [W-1:0]         rem_r;
  logic [W-1:0]         quo;       // dividend bits shift out the top, quotient bits in the bottom
  logic [W-1:0]         dvsr;

  logic         accept;
  logic         sgn1, sgn2, is_div;
  logic [W-1:0] op_a, op_b, mag_a, mag_b;
  logic         sign_a, sign_b;
  logic         div_zero, div_ovf, fast;
  logic [W-1:0] fast_res;

  assign in_ready  = (state == IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Operand preparation: width selection, signedness, magnitudes, fast paths.
  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    case (func3)
      3'b000, 3'b001, 3'b100, 3'b110: begin sgn1 = 1'b1; sgn2 = 1'b1; end
      3'b010:                         begin sgn1 = 1'b1; sgn2 = 1'b0; end
      default:                        begin sgn1 = 1'b0; sgn2 = 1'b0; end
    endcase
    is_div = func3[2];
    op_a   = is_word ? ext_half(src1[H-1:0], sgn1) : src1;
    op_b   = is_word ? ext_half(src2[H-1:0], sgn2) : src2;
    sign_a = sgn1 & op_a[W-1];
    sign_b = sgn2 & op_b[W-1];
    mag_a  = neg_w(op_a, sign_a);
    mag_b  = neg_w(op_b, sign_b);

    div_zero = is_div && (op_b == '0);
    if (is_word)
      div_ovf = is_div && !func3[0] && (src1[H-1:0] == MIN_H) && (&src2[H-1:0]);
    else
      div_ovf = is_div && !func3[0] && (src1 == MIN_W) && (&src2);
    fast = div_zero || div_ovf;

    // func3[1] selects remainder. Zero divisor: q = all ones, r = dividend.
    // Overflow: q = dividend, r = 0.
    if (div_zero)
      fast_res = func3[1] ? op_a : '1;
    else
      fast_res = func3[1] ? '0 : op_a;
  end

  // One iteration step and final result selection.
  logic [W:0]     rem_shift, rem_sub;
  logic           rem_ge;
  logic [2*W-1:0] prod;
  logic [W-1:0]   raw, final_res;

  always_comb begin
    rem_shift = {rem_r, quo[W-1]};
    rem_sub   = rem_shift - {1'b0, dvsr};
    rem_ge    = !rem_sub[W];

    prod = neg_2w(acc, neg_q);
    case (op_f3)
      3'b000:                 raw = prod[W-1:0];
      3'b001, 3'b010, 3'b011: raw = prod[2*W-1:W];
      3'b100, 3'b101:         raw = neg_w(quo, neg_q);
      default:                raw = neg_w(rem_r, neg_r);
    endcase
    if (fast_q)
      raw = fast_val;
    final_res = op_word ? ext_half(raw[H-1:0], 1'b1) : raw;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid && !flush) state_next = CALC;
      CALC:    if (cnt == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush)
      state_next = IDLE;
  end

  // Datapath. A fast-path request loads a zero count so it spends a single
  // cycle in CALC and then lands in DONE with the precomputed value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_f3    <= '0;
      op_word  <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      fast_q   <= 1'b0;
      fast_val <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem_r    <= '0;
      quo      <= '0;
      dvsr     <= '0;
      result   <= '0;
    end else if (accept) begin
      cnt      <= fast ? '0 : (is_word ? ITER_H : ITER_W);
      op_f3    <= func3;
      op_word  <= is_word;
      neg_q    <= sign_a ^ sign_b;
      neg_r    <= sign_a;
      fast_q   <= fast;
      fast_val <= fast_res;
      acc      <= '0;
      mcand    <= {{W{1'b0}}, mag_a};
      mplier   <= mag_b;
      rem_r    <= '0;
      // Word dividends start at the top so the same MSB-first shift applies.
      quo      <= is_word ? (mag_a << H) : mag_a;
      dvsr     <= mag_b;
    end else if (state == CALC && !flush) begin
      if (cnt == '0) begin
        result <= final_res;
      end else begin
        cnt <= cnt - CNT_WIDTH'(1);
        if (op_f3[2]) begin
          rem_r <= rem_ge ? rem_sub[W-1:0] : rem_shift[W-1:0];
          quo   <= {quo[W-2:0], rem_ge};
        end else begin
          if (mplier[0])
            acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end
      end
    end
  end

endmodule
